// File: rtl/dm_arbiter_pkg.sv
// Shared size codes, FSM states and helpers for the data-memory arbiter.
package dm_arbiter_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StMerge  = 2'b10,
        StResp   = 2'b11
    } dm_state_e;

    typedef enum logic {
        PortC = 1'b0,
        PortD = 1'b1
    } dm_port_e;

    // Size 11, odd halfword and non-word-aligned word accesses are rejected.
    function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic illegal;
        case (size)
            SZ_WORD: illegal = (addr_lo != 2'b00);
            SZ_HALF: illegal = addr_lo[0];
            SZ_BYTE: illegal = 1'b0;
            default: illegal = 1'b1;
        endcase
        return illegal;
    endfunction

endpackage

// File: rtl/dm_store_merge.sv
// Combinational lane merge for sub-word stores: replaces one byte or halfword lane
// of the word read from memory, preserving every other bit.
module dm_store_merge
    import dm_arbiter_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [15:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] merged_o
);

    // Start from the old word and overwrite only the addressed lane.
    always_comb begin
        merged_o = old_word_i;
        case (size_i)
            SZ_HALF: begin
                if (addr_lo_i[1]) merged_o[31:16] = wdata_i;
                else              merged_o[15:0]  = wdata_i;
            end
            SZ_BYTE: merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port sequencer in front of the word-wide data memory. Arbitrates port C and
// port D, turns byte/halfword stores into read-modify-write, returns raw words.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [1:0]        c_size,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [31:0]       c_wdata,
    output logic              c_ack,
    output logic              c_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [31:0]       rdata,
    output logic [31:0]       dm_addr,
    output logic [31:0]       dm_wdata,
    output logic              dm_we,
    input  logic [31:0]       dm_rdata
);

    dm_state_e   state_q, state_d;
    dm_port_e    id_q, id_d, last_q, last_d;
    logic        we_q, we_d, err_q, err_d;
    logic [1:0]  size_q, size_d, addr_lo_q, addr_lo_d;
    logic [31:0] wdata_q, wdata_d;
    logic        c_ack_q, c_ack_d, d_ack_q, d_ack_d;
    logic        c_err_q, c_err_d, d_err_q, d_err_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d, rdata_q, rdata_d;

    dm_port_e    grant_id;
    logic        sel_we, sel_illegal;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr, sel_wdata, merged_word;

    dm_store_merge u_merge (
        .old_word_i (dm_rdata),
        .wdata_i    (wdata_q[15:0]),
        .size_i     (size_q),
        .addr_lo_i  (addr_lo_q),
        .merged_o   (merged_word)
    );

    // Pick the winner among pending requests and mux its fields.
    always_comb begin
        if (FIXED_PRIO)              grant_id = c_req ? PortC : PortD;
        else if (c_req && d_req)     grant_id = (last_q == PortC) ? PortD : PortC;
        else                         grant_id = c_req ? PortC : PortD;
        sel_we      = (grant_id == PortC) ? c_we : d_we;
        sel_size    = (grant_id == PortC) ? c_size : d_size;
        sel_addr    = (grant_id == PortC) ? 32'(c_addr) : 32'(d_addr);
        sel_wdata   = (grant_id == PortC) ? c_wdata : d_wdata;
        sel_illegal = access_illegal(sel_size, sel_addr[1:0]);
    end

    // Next-state and registered-output logic; acks/dm_we default to a single-cycle pulse.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        last_d     = last_q;
        we_d       = we_q;
        err_d      = err_q;
        size_d     = size_q;
        addr_lo_d  = addr_lo_q;
        wdata_d    = wdata_q;
        c_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        c_err_d    = 1'b0;
        d_err_d    = 1'b0;
        dm_we_d    = 1'b0;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (c_req || d_req) begin
                    id_d      = grant_id;
                    last_d    = grant_id;
                    we_d      = sel_we;
                    size_d    = sel_size;
                    addr_lo_d = sel_addr[1:0];
                    wdata_d   = sel_wdata;
                    err_d     = sel_illegal;
                    // Errors still spend the ACCESS slot, with no memory activity,
                    // so every non-RMW access acks with the same latency.
                    state_d   = StAccess;
                    if (!sel_illegal) begin
                        dm_addr_d = {sel_addr[31:2], 2'b00};
                        if (sel_we && sel_size == SZ_WORD) begin
                            dm_we_d    = 1'b1;
                            dm_wdata_d = sel_wdata;
                        end
                    end
                end
            end
            StAccess: begin
                if (!err_q && we_q && size_q != SZ_WORD) begin
                    dm_we_d    = 1'b1;
                    dm_wdata_d = merged_word;
                    state_d    = StMerge;
                end else begin
                    if (!err_q && !we_q) rdata_d = dm_rdata;
                    c_ack_d = (id_q == PortC);
                    d_ack_d = (id_q == PortD);
                    c_err_d = (id_q == PortC) && err_q;
                    d_err_d = (id_q == PortD) && err_q;
                    state_d = StResp;
                end
            end
            StMerge: begin
                c_ack_d = (id_q == PortC);
                d_ack_d = (id_q == PortD);
                state_d = StResp;
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset abandons any RMW in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            id_q       <= PortC;
            last_q     <= PortD;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= SZ_WORD;
            addr_lo_q  <= 2'b00;
            wdata_q    <= '0;
            c_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            c_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            last_q     <= last_d;
            we_q       <= we_d;
            err_q      <= err_d;
            size_q     <= size_d;
            addr_lo_q  <= addr_lo_d;
            wdata_q    <= wdata_d;
            c_ack_q    <= c_ack_d;
            d_ack_q    <= d_ack_d;
            c_err_q    <= c_err_d;
            d_err_q    <= d_err_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    assign c_ack    = c_ack_q;
    assign d_ack    = d_ack_q;
    assign c_err    = c_err_q;
    assign d_err    = d_err_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_wdata = dm_wdata_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: a round-robin instance and a fixed-priority
// instance, each with its own behavioural word memory.
module tb_dm_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        c_req, c_we, d_req, d_we;
    logic [1:0]  c_size, d_size;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;

    logic        c_ack, c_err, d_ack, d_err, dm_we;
    logic [31:0] rdata, dm_addr, dm_wdata, dm_rdata;
    logic        fp_c_ack, fp_c_err, fp_d_ack, fp_d_err, fp_dm_we;
    logic [31:0] fp_rdata, fp_dm_addr, fp_dm_wdata, fp_dm_rdata;

    logic [31:0] mem    [0:3071];
    logic [31:0] mem_fp [0:3071];
    logic        pre_en = 1'b0;
    logic [11:0] pre_idx = '0;
    logic [31:0] pre_val = '0;

    int unsigned we_total = 0, c_ack_total = 0, d_ack_total = 0;
    int n_cmp = 0, n_fail = 0;

    dm_arbiter #(.ADDR_W(32), .FIXED_PRIO(1'b0)) u_dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err),
        .rdata(rdata), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
        .dm_rdata(dm_rdata)
    );

    dm_arbiter #(.ADDR_W(32), .FIXED_PRIO(1'b1)) u_dut_fp (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(fp_c_ack), .c_err(fp_c_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(fp_d_ack), .d_err(fp_d_err),
        .rdata(fp_rdata), .dm_addr(fp_dm_addr), .dm_wdata(fp_dm_wdata), .dm_we(fp_dm_we),
        .dm_rdata(fp_dm_rdata)
    );

    assign dm_rdata    = mem[dm_addr[13:2]];
    assign fp_dm_rdata = mem_fp[fp_dm_addr[13:2]];

    // Memory models: DUT write port, plus a bench preload port used only while idle.
    always @(posedge clk) begin
        if (dm_we)       mem[dm_addr[13:2]] <= dm_wdata;
        else if (pre_en) mem[pre_idx] <= pre_val;
        if (fp_dm_we)    mem_fp[fp_dm_addr[13:2]] <= fp_dm_wdata;
        else if (pre_en) mem_fp[pre_idx] <= pre_val;
    end

    // Running event counts on the round-robin instance.
    always @(posedge clk) begin
        if (dm_we) we_total <= we_total + 1;
        if (c_ack) c_ack_total <= c_ack_total + 1;
        if (d_ack) d_ack_total <= d_ack_total + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pre_en  = 1'b1;
        pre_idx = idx[11:0];
        pre_val = val;
        tick();
        pre_en  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({c_ack, d_ack, c_err, d_err, dm_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000", {c_ack, d_ack, c_err, d_err, dm_we});
        end
        n_cmp++;
        if (dm_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_dm_addr: got %h want 00000000", dm_addr);
        end
        n_cmp++;
        if (dm_wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_dm_wdata: got %h want 00000000", dm_wdata);
        end
        n_cmp++;
        if (rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h want 00000000", rdata);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_word_store_load();
        int unsigned we0;
        we0 = we_total;
        c_req = 1'b1; c_we = 1'b1; c_size = 2'b00; c_addr = 32'h10; c_wdata = 32'hDEADBEEF;
        tick();
        n_cmp++;
        if ({dm_we, dm_wdata, dm_addr, c_ack} !== {1'b1, 32'hDEADBEEF, 32'h10, 1'b0}) begin
            n_fail++;
            $display("FAIL wstore_access: got we=%b wdata=%h addr=%h ack=%b want 1 deadbeef 10 0",
                     dm_we, dm_wdata, dm_addr, c_ack);
        end
        tick();
        n_cmp++;
        if ({c_ack, c_err, dm_we} !== 3'b100) begin
            n_fail++; $display("FAIL wstore_ack: got ack/err/we=%b want 100", {c_ack, c_err, dm_we});
        end
        c_req = 1'b0;
        tick();
        n_cmp++;
        if (mem[4] !== 32'hDEADBEEF || we_total - we0 != 1) begin
            n_fail++;
            $display("FAIL wstore_mem: got %h pulses=%0d want deadbeef pulses=1",
                     mem[4], we_total - we0);
        end
        c_req = 1'b1; c_we = 1'b0; c_wdata = 32'h0;
        tick();
        n_cmp++;
        if (c_ack !== 1'b0) begin
            n_fail++; $display("FAIL load_early_ack: got %b want 0", c_ack);
        end
        tick();
        n_cmp++;
        if ({c_ack, rdata} !== {1'b1, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL load_rdata: got ack=%b rdata=%h want 1 deadbeef", c_ack, rdata);
        end
        c_req = 1'b0;
        tick();
    endtask

    task automatic test_byte_rmw();
        int unsigned we0;
        preload(8, 32'h11223344);
        we0 = we_total;
        c_req = 1'b1; c_we = 1'b1; c_size = 2'b10; c_addr = 32'h21; c_wdata = 32'h000000AA;
        tick();
        n_cmp++;
        if ({dm_we, c_ack} !== 2'b00) begin
            n_fail++; $display("FAIL byte_access: got we/ack=%b want 00", {dm_we, c_ack});
        end
        tick();
        n_cmp++;
        if ({dm_we, dm_wdata, c_ack} !== {1'b1, 32'h1122AA44, 1'b0}) begin
            n_fail++;
            $display("FAIL byte_merge: got we=%b wdata=%h ack=%b want 1 1122aa44 0",
                     dm_we, dm_wdata, c_ack);
        end
        tick();
        n_cmp++;
        if ({c_ack, dm_we} !== 2'b10) begin
            n_fail++; $display("FAIL byte_ack: got ack/we=%b want 10", {c_ack, dm_we});
        end
        c_req = 1'b0;
        tick();
        n_cmp++;
        if (mem[8] !== 32'h1122AA44 || we_total - we0 != 1) begin
            n_fail++;
            $display("FAIL byte_mem: got %h pulses=%0d want 1122aa44 pulses=1",
                     mem[8], we_total - we0);
        end
    endtask

    task automatic test_half_rmw();
        int unsigned c0;
        preload(8, 32'h11223344);
        c0 = c_ack_total;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b01; d_addr = 32'h22; d_wdata = 32'h0000BEEF;
        tick();
        tick();
        n_cmp++;
        if ({dm_we, dm_wdata} !== {1'b1, 32'hBEEF3344}) begin
            n_fail++; $display("FAIL half_merge: got we=%b wdata=%h want 1 beef3344", dm_we, dm_wdata);
        end
        tick();
        n_cmp++;
        if ({d_ack, d_err} !== 2'b10) begin
            n_fail++; $display("FAIL half_ack: got ack/err=%b want 10", {d_ack, d_err});
        end
        d_req = 1'b0;
        tick();
        n_cmp++;
        if (mem[8] !== 32'hBEEF3344 || c_ack_total != c0) begin
            n_fail++;
            $display("FAIL half_mem: got %h c_acks=%0d want beef3344 c_acks=0",
                     mem[8], c_ack_total - c0);
        end
    endtask

    task automatic test_contention();
        logic exp_c;
        preload(16, 32'hC0C0C0C0);
        preload(17, 32'hD0D0D0D0);
        c_req = 1'b1; c_we = 1'b0; c_size = 2'b00; c_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h44;
        for (int t = 0; t < 4; t++) begin
            tick();
            tick();
            exp_c = (t % 2 == 0);
            n_cmp++;
            if ({c_ack, d_ack} !== (exp_c ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: got c/d=%b want %b", t, {c_ack, d_ack},
                         exp_c ? 2'b10 : 2'b01);
            end
            n_cmp++;
            if (rdata !== (exp_c ? 32'hC0C0C0C0 : 32'hD0D0D0D0)) begin
                n_fail++; $display("FAIL rr_rdata_%0d: got %h", t, rdata);
            end
            n_cmp++;
            if ({fp_c_ack, fp_d_ack, fp_rdata} !== {2'b10, 32'hC0C0C0C0}) begin
                n_fail++;
                $display("FAIL fp_grant_%0d: got c/d=%b rdata=%h want 10 c0c0c0c0",
                         t, {fp_c_ack, fp_d_ack}, fp_rdata);
            end
            tick();
        end
        c_req = 1'b0;
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_misaligned();
        int unsigned we0;
        we0 = we_total;
        c_req = 1'b1; c_we = 1'b0; c_size = 2'b00; c_addr = 32'h22;
        tick();
        n_cmp++;
        if (c_ack !== 1'b0) begin
            n_fail++; $display("FAIL mis_word_early: got ack=%b want 0", c_ack);
        end
        tick();
        n_cmp++;
        if ({c_ack, c_err} !== 2'b11) begin
            n_fail++; $display("FAIL mis_word_load: got ack/err=%b want 11", {c_ack, c_err});
        end
        c_req = 1'b0;
        tick();
        c_req = 1'b1; c_we = 1'b1; c_size = 2'b01; c_addr = 32'h13; c_wdata = 32'h1234;
        tick();
        tick();
        n_cmp++;
        if ({c_ack, c_err} !== 2'b11) begin
            n_fail++; $display("FAIL mis_half_store: got ack/err=%b want 11", {c_ack, c_err});
        end
        c_req = 1'b0;
        tick();
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b11; d_addr = 32'h0; d_wdata = 32'hFFFFFFFF;
        tick();
        tick();
        n_cmp++;
        if ({d_ack, d_err, c_ack} !== 3'b110) begin
            n_fail++; $display("FAIL mis_size11: got d_ack/d_err/c_ack=%b want 110",
                               {d_ack, d_err, c_ack});
        end
        d_req = 1'b0;
        tick();
        n_cmp++;
        if (we_total != we0) begin
            n_fail++; $display("FAIL mis_no_write: got %0d dm_we cycles want 0", we_total - we0);
        end
    endtask

    task automatic test_reset_mid_rmw();
        int unsigned c0;
        preload(12, 32'h55667788);
        c0 = c_ack_total;
        c_req = 1'b1; c_we = 1'b1; c_size = 2'b10; c_addr = 32'h30; c_wdata = 32'h000000FF;
        tick();
        tick();
        n_cmp++;
        if (dm_we !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_merge: got dm_we=%b want 1", dm_we);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({dm_we, c_ack, d_ack, c_err, d_err, dm_addr, dm_wdata, rdata} !== 101'b0) begin
            n_fail++;
            $display("FAIL rst_async: got we=%b addr=%h wdata=%h rdata=%h want all zero",
                     dm_we, dm_addr, dm_wdata, rdata);
        end
        c_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (mem[12] !== 32'h55667788 || c_ack_total != c0) begin
            n_fail++;
            $display("FAIL rst_mem_kept: got %h acks=%0d want 55667788 acks=0",
                     mem[12], c_ack_total - c0);
        end
        // First tie after reset goes to C even though C was granted last before reset.
        c_req = 1'b1; c_we = 1'b0; c_size = 2'b00; c_addr = 32'h30;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h44;
        tick();
        tick();
        n_cmp++;
        if ({c_ack, d_ack, rdata} !== {2'b10, 32'h55667788}) begin
            n_fail++;
            $display("FAIL rst_first_tie: got c/d=%b rdata=%h want 10 55667788",
                     {c_ack, d_ack}, rdata);
        end
        c_req = 1'b0;
        d_req = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_size = 2'b00; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
        test_reset();
        test_word_store_load();
        test_byte_rmw();
        test_half_rmw();
        test_contention();
        test_misaligned();
        test_reset_mid_rmw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
